// File: rtl/tinker_pkg.sv
// Shared types and helpers for the Tinker program loader: FSM states,
// memory capacity and the length-header / address helpers.
package tinker_pkg;

  localparam int unsigned TINKER_MEM_WORDS = 32768;

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_SUM,
    S_DONE,
    S_ERR
  } loader_state_t;

  // Decide where a freshly received length header sends the loader.
  function automatic loader_state_t len_next_state(input logic [31:0] len,
                                                   input logic [31:0] mem_words);
    loader_state_t nxt;
    if (len > mem_words) begin
      nxt = S_ERR;
    end else if (len == 32'd0) begin
      nxt = S_SUM;
    end else begin
      nxt = S_DATA;
    end
    return nxt;
  endfunction

  // Byte address of word idx; wraps modulo 2^32 by construction.
  function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                 input logic [31:0] idx);
    return base + {idx[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/tinker_byte_packer.sv
// Collects four stream bytes into a little-endian 32-bit word and pulses
// word_valid on the byte that completes it.
module tinker_byte_packer
  import tinker_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  byte_cnt;
  logic [23:0] pack;

  // The completing byte is not registered; the word is presented the same
  // cycle so the owner can register it on the accepting edge.
  assign word_valid = byte_en && (byte_cnt == 2'd3);
  assign word       = {byte_data, pack};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt <= 2'd0;
      pack     <= 24'd0;
    end else if (clear) begin
      byte_cnt <= 2'd0;
      pack     <= 24'd0;
    end else if (byte_en) begin
      byte_cnt <= byte_cnt + 2'd1;
      pack     <= {byte_data, pack[23:8]};
    end
  end

endmodule

// File: rtl/tinker_program_loader.sv
// Writer side of the Tinker instruction memory: parses a length-framed,
// checksummed byte stream, writes the words and releases tinker_core on success.
module tinker_program_loader
  import tinker_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = TINKER_MEM_WORDS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  input  logic        start,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_reset,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);

  loader_state_t state;
  loader_state_t len_next;
  logic [31:0]   len;
  logic [31:0]   word_idx;
  logic [7:0]    sum;
  logic          accept;
  logic          byte_en;
  logic          restart;
  logic          word_valid;
  logic [31:0]   word;

  assign rx_ready = (state == S_LEN) || (state == S_DATA) || (state == S_SUM);
  assign accept   = rx_valid && rx_ready;
  assign byte_en  = accept && ((state == S_LEN) || (state == S_DATA));
  assign restart  = start && ((state == S_DONE) || (state == S_ERR));

  always_comb begin
    len_next = len_next_state(word, MEM_LIMIT);
  end

  tinker_byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (restart),
    .byte_en    (byte_en),
    .byte_data  (rx_data),
    .word_valid (word_valid),
    .word       (word)
  );

  // Single FSM owning the checksum, address counter and all registered
  // outputs; the write strobe is a one-cycle pulse raised on the edge that
  // completes a data word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_LEN;
      len          <= 32'd0;
      word_idx     <= 32'd0;
      sum          <= 8'd0;
      mem_write    <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      core_reset   <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= 16'd0;
    end else begin
      mem_write <= 1'b0;
      case (state)
        S_LEN: begin
          if (accept) begin
            sum <= sum + rx_data;
            if (word_valid) begin
              len   <= word;
              state <= len_next;
              if (len_next == S_ERR) begin
                error <= 1'b1;
              end
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            sum <= sum + rx_data;
            if (word_valid) begin
              mem_write    <= 1'b1;
              mem_wdata    <= word;
              mem_addr     <= word_byte_addr(BASE_ADDR, word_idx);
              word_idx     <= word_idx + 32'd1;
              words_loaded <= words_loaded + 16'd1;
              if ((word_idx + 32'd1) == len) begin
                state <= S_SUM;
              end
            end
          end
        end
        S_SUM: begin
          // The checksum byte itself is compared, never accumulated.
          if (accept) begin
            if (rx_data == sum) begin
              state      <= S_DONE;
              done       <= 1'b1;
              core_reset <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_LEN;
            core_reset   <= 1'b1;
            done         <= 1'b0;
            error        <= 1'b0;
            len          <= 32'd0;
            word_idx     <= 32'd0;
            sum          <= 8'd0;
            words_loaded <= 16'd0;
          end
        end
        default: begin
          state <= S_LEN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tinker_program_loader.sv
// Scoreboard bench for tinker_program_loader: a stream-level model queues the
// expected writes, a negedge monitor checks every mem_write as it appears.
module tb_tinker_program_loader;
  import tinker_pkg::*;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int unsigned MEMW = 32768;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        start;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_reset;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  tinker_program_loader #(.BASE_ADDR(BASE), .MEM_WORDS(MEMW)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .start        (start),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .core_reset   (core_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  int          due_q[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every write must match the next modelled word and appear exactly
  // one cycle after the byte that completed it; core is held until done.
  logic [31:0] mon_addr, mon_data;
  int          mon_due;
  always @(negedge clk) begin
    if (reset) begin
      checkOutput("core_reset_until_done", {31'd0, core_reset}, {31'd0, ~done});
      if (mem_write) begin
        if (exp_addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got addr 0x%08h data 0x%08h, expected no write", mem_addr, mem_wdata);
        end else begin
          mon_addr = exp_addr_q.pop_front();
          mon_data = exp_data_q.pop_front();
          checkOutput("write_addr", mem_addr, mon_addr);
          checkOutput("write_data", mem_wdata, mon_data);
          if (due_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL write_timing: got write at cycle %0d, expected none before 4th byte", cyc);
          end else begin
            mon_due = due_q.pop_front();
            checkOutput("write_cycle", 32'(cyc), 32'(mon_due + 1));
          end
        end
      end
    end
  end

  // Reference model working on the whole framed stream at once.
  task automatic modelStream(input logic [7:0] s[$], output bit e_done, output bit e_err,
                             output logic [31:0] e_words);
    logic [31:0] n;
    logic [7:0]  sum;
    n       = {s[3], s[2], s[1], s[0]};
    e_done  = 1'b0;
    e_err   = 1'b0;
    e_words = 32'd0;
    if (n > 32'(MEMW)) begin
      e_err = 1'b1;
      return;
    end
    for (int i = 0; i < int'(n); i++) begin
      exp_addr_q.push_back(BASE + 32'(4 * i));
      exp_data_q.push_back({s[4*i+7], s[4*i+6], s[4*i+5], s[4*i+4]});
    end
    e_words = n;
    sum = 8'd0;
    for (int i = 0; i < s.size() - 1; i++) sum += s[i];
    if (s[s.size()-1] == sum) e_done = 1'b1;
    else e_err = 1'b1;
  endtask

  // Entry and exit point: 1 time unit after a rising edge.
  task automatic sendByte(input logic [7:0] b, input int gap, input bit with_start, input bit word_end);
    int waited;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    start    = with_start;
    waited   = 0;
    @(negedge clk);
    while (!rx_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!rx_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL rx_ready_timeout: got rx_ready=0 for 50 cycles, expected 1");
    end else if (word_end) begin
      due_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic applyStimulus(input logic [7:0] s[$], input int max_gap, input bit noise);
    logic [31:0] n;
    bit          nvalid;
    bit          wend;
    bit          last;
    bit          ws;
    int          gap;
    n      = {s[3], s[2], s[1], s[0]};
    nvalid = (n <= 32'(MEMW));
    for (int i = 0; i < s.size(); i++) begin
      gap  = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      wend = nvalid && (i >= 4) && (i < 4 + 4 * int'(n)) && (((i - 4) % 4) == 3);
      last = (i == s.size() - 1);
      ws   = noise && !last && ($urandom_range(0, 3) == 0);
      sendByte(s[i], gap, ws, wend);
    end
  endtask

  task automatic runLoad(input logic [7:0] s[$], input int max_gap, input bit noise);
    bit          e_done, e_err;
    logic [31:0] e_words;
    modelStream(s, e_done, e_err, e_words);
    applyStimulus(s, max_gap, noise);
    @(negedge clk);
    checkOutput("done", {31'd0, done}, {31'd0, e_done});
    checkOutput("error", {31'd0, error}, {31'd0, e_err});
    checkOutput("core_reset", {31'd0, core_reset}, {31'd0, ~e_done});
    checkOutput("rx_ready_end", {31'd0, rx_ready}, 32'd0);
    checkOutput("words_loaded", {16'd0, words_loaded}, {16'd0, e_words[15:0]});
    checkOutput("pending_writes", 32'(exp_addr_q.size()), 32'd0);
    exp_addr_q.delete();
    exp_data_q.delete();
    due_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    checkOutput("restart_done", {31'd0, done}, 32'd0);
    checkOutput("restart_error", {31'd0, error}, 32'd0);
    checkOutput("restart_core_reset", {31'd0, core_reset}, 32'd1);
    checkOutput("restart_words", {16'd0, words_loaded}, 32'd0);
    checkOutput("restart_rx_ready", {31'd0, rx_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState();
    checkOutput("rst_mem_write", {31'd0, mem_write}, 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_core_reset", {31'd0, core_reset}, 32'd1);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_error", {31'd0, error}, 32'd0);
    checkOutput("rst_words", {16'd0, words_loaded}, 32'd0);
    checkOutput("rst_rx_ready", {31'd0, rx_ready}, 32'd1);
  endtask

  task automatic makeRandom(output logic [7:0] s[$]);
    int unsigned kind;
    logic [31:0] n;
    logic [7:0]  sum;
    logic [7:0]  b;
    s    = {};
    kind = $urandom_range(0, 5);
    if (kind == 0) begin
      n = 32'(MEMW) + 32'd1 + 32'($urandom_range(0, 100000));
      for (int k = 0; k < 4; k++) s.push_back(n[8*k +: 8]);
      return;
    end
    n = 32'($urandom_range(0, 6));
    for (int k = 0; k < 4; k++) s.push_back(n[8*k +: 8]);
    for (int k = 0; k < 4 * int'(n); k++) begin
      b = 8'($urandom_range(0, 255));
      s.push_back(b);
    end
    sum = 8'd0;
    foreach (s[k]) sum += s[k];
    if (kind == 1) s.push_back(sum ^ 8'(1 << $urandom_range(0, 7)));
    else s.push_back(sum);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] t1[$], t2[$], t3[$], t4[$], t5[$], part[$], rs[$];
    t1 = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
           8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hDB};
    t2 = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    t3 = t1;
    t3[12] = 8'hDC;
    t4 = '{8'h01, 8'h80, 8'h00, 8'h00};
    t5 = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    part = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56};

    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'd0;
    start    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState();
    @(posedge clk);
    #1;
    reset = 1'b1;

    $display("[TB] basic two-word load");
    runLoad(t1, 0, 1'b0);
    $display("[TB] zero-length load");
    pulseStart();
    runLoad(t2, 0, 1'b0);
    $display("[TB] bad checksum");
    pulseStart();
    runLoad(t3, 0, 1'b0);
    $display("[TB] restart from error");
    pulseStart();
    runLoad(t1, 0, 1'b0);
    $display("[TB] oversize length");
    pulseStart();
    runLoad(t4, 0, 1'b0);
    pulseStart();
    runLoad(t5, 0, 1'b0);
    $display("[TB] gapped stream");
    pulseStart();
    runLoad(t1, 5, 1'b0);

    $display("[TB] reset mid-load");
    pulseStart();
    applyStimulus(part, 0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    checkResetState();
    @(posedge clk);
    #1;
    reset = 1'b1;
    runLoad(t1, 0, 1'b0);

    $display("[TB] randomized loads");
    for (int r = 0; r < 16; r++) begin
      pulseStart();
      makeRandom(rs);
      runLoad(rs, 3, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
